player_crash_controller: RTL and testbench

// Consumes the per-frame collision flags produced by the collision manager and

---
 rtl/player_crash_controller.sv | 92 +++++++++
 tb/tb_player_crash_controller.sv | 138 +++++++++++++
 2 files changed

// File: rtl/player_crash_controller.sv
// player_crash_controller: per-frame crash/respawn FSM with lives, blink and fuel pickup events
module player_crash_controller #(
  parameter int CRASH_FRAMES  = 60,
  parameter int INVULN_FRAMES = 90,
  parameter int BLINK_PERIOD  = 8,
  parameter int LIVES_INIT    = 3
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       frame_start,
  input  logic [0:1] collisions,
  input  logic       restart,
  output logic       crash_active,
  output logic       speed_freeze,
  output logic       invulnerable,
  output logic       player_visible,
  output logic       fuel_pickup,
  output logic [1:0] lives,
  output logic       game_over
);
  typedef enum logic [1:0] {DRIVING, CRASHED, RESPAWN, GAME_OVER} state_t;
  localparam logic [7:0] CRASH_LD  = 8'(CRASH_FRAMES - 1);
  localparam logic [7:0] INVULN_LD = 8'(INVULN_FRAMES - 1);
  localparam logic [7:0] BLINK_TOP = 8'(BLINK_PERIOD - 1);
  localparam logic [1:0] LIVES_LD  = 2'(LIVES_INIT);
  state_t     state, state_n;
  logic [7:0] cnt, cnt_n, blink, blink_n;
  logic [1:0] lives_n;
  logic       vis_n, fuel_prev, fuel_prev_n, pickup_n, hit;
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    blink_n     = blink;
    lives_n     = lives;
    vis_n       = player_visible;
    pickup_n    = 1'b0;
    fuel_prev_n = frame_start ? collisions[1] : fuel_prev;
    hit         = frame_start && state == DRIVING && collisions[0];
    if (restart) begin
      state_n = DRIVING;
      cnt_n   = '0;
      blink_n = '0;
      lives_n = LIVES_LD;
      vis_n   = 1'b1;
    end else if (frame_start) begin
      // a crash on this tick swallows any simultaneous fuel edge
      pickup_n = collisions[1] && !fuel_prev && !hit && (state == DRIVING || state == RESPAWN);
      case (state)
        DRIVING: if (collisions[0]) begin
          lives_n = lives <= 2'd1 ? 2'd0 : lives - 2'd1;
          state_n = lives <= 2'd1 ? GAME_OVER : CRASHED;
          cnt_n   = lives <= 2'd1 ? cnt : CRASH_LD;
        end
        CRASHED: begin
          state_n = cnt == 8'd0 ? RESPAWN : CRASHED;
          cnt_n   = cnt == 8'd0 ? INVULN_LD : cnt - 8'd1;
          blink_n = cnt == 8'd0 ? 8'd0 : blink;
        end
        RESPAWN: begin
          state_n = cnt == 8'd0 ? DRIVING : RESPAWN;
          cnt_n   = cnt == 8'd0 ? 8'd0 : cnt - 8'd1;
          blink_n = cnt == 8'd0 || blink == BLINK_TOP ? 8'd0 : blink + 8'd1;
          vis_n   = cnt == 8'd0 ? 1'b1 : (blink == BLINK_TOP ? !player_visible : player_visible);
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state          <= DRIVING;
      cnt            <= '0;
      blink          <= '0;
      lives          <= LIVES_LD;
      player_visible <= 1'b1;
      fuel_prev      <= 1'b0;
      fuel_pickup    <= 1'b0;
    end else begin
      state          <= state_n;
      cnt            <= cnt_n;
      blink          <= blink_n;
      lives          <= lives_n;
      player_visible <= vis_n;
      fuel_prev      <= fuel_prev_n;
      fuel_pickup    <= pickup_n;
    end
  end
  assign crash_active = state == CRASHED;
  assign speed_freeze = state == CRASHED || state == GAME_OVER;
  assign invulnerable = state == RESPAWN;
  assign game_over    = state == GAME_OVER;
endmodule

// File: tb/tb_player_crash_controller.sv
// tb_player_crash_controller: vector table, directed corner sequences and random run against a frame-level model
module tb_player_crash_controller;
  localparam int CF = 60, IVF = 90, BP = 8, LI = 3;
  logic clk = 1'b0, resetN = 1'b0, frame_start = 1'b0, restart = 1'b0;
  logic [0:1] collisions = '0;
  logic crash_active, speed_freeze, invulnerable, player_visible, fuel_pickup, game_over;
  logic [1:0] lives;
  int tests = 0, fails = 0, pulses;
  int m_lives, m_crash, m_resp, m_el;
  bit m_over, m_prev, m_pick;
  typedef struct {bit fs, c0, c1, rs; logic [7:0] exp;} vec_t;
  vec_t tbl[12];
  always #5 clk = ~clk;
  player_crash_controller dut (
    .clk(clk), .resetN(resetN), .frame_start(frame_start), .collisions(collisions),
    .restart(restart), .crash_active(crash_active), .speed_freeze(speed_freeze),
    .invulnerable(invulnerable), .player_visible(player_visible), .fuel_pickup(fuel_pickup),
    .lives(lives), .game_over(game_over)
  );
  function automatic logic [7:0] outs();
    return {crash_active, speed_freeze, invulnerable, player_visible, fuel_pickup, lives, game_over};
  endfunction
  function automatic logic [7:0] model_out();
    logic vis;
    vis = m_resp > 0 ? ((m_el / BP) % 2 == 0) : 1'b1;
    return {m_crash > 0, m_crash > 0 || m_over, m_resp > 0, vis, m_pick, 2'(m_lives), m_over};
  endfunction
  task automatic model_reset();
    m_lives = LI; m_crash = 0; m_resp = 0; m_el = 0; m_over = 0; m_prev = 0; m_pick = 0;
  endtask
  // frame-level view: frames left frozen, frames left invulnerable, frames since respawn began
  task automatic model_step(input bit fs, c0, c1, rs);
    bit drv, live, hit;
    drv  = !m_over && m_crash == 0 && m_resp == 0;
    live = drv || m_resp > 0;
    hit  = fs && drv && c0;
    m_pick = 0;
    if (rs) begin
      m_lives = LI; m_crash = 0; m_resp = 0; m_el = 0; m_over = 0;
    end else if (fs) begin
      m_pick = c1 && !m_prev && live && !hit;
      if (m_crash > 0) begin
        m_crash--;
        if (m_crash == 0) begin m_resp = IVF; m_el = 0; end
      end else if (m_resp > 0) begin
        m_resp--; m_el++;
      end else if (hit) begin
        m_lives--;
        if (m_lives == 0) m_over = 1; else m_crash = CF;
      end
    end
    if (fs) m_prev = c1;
  endtask
  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b (crash,freeze,inv,vis,fuel,lives[2],over)", name, got, exp);
    end
  endtask
  task automatic check1(input string name, input logic got, input logic exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask
  task automatic step(input bit fs, c0, c1, rs);
    frame_start = fs; collisions[0] = c0; collisions[1] = c1; restart = rs;
    @(posedge clk); #1;
    model_step(fs, c0, c1, rs);
    check("model", outs(), model_out());
  endtask
  initial begin
    tbl = '{'{1,0,0,0,8'h16}, '{1,0,0,0,8'h16}, '{1,0,0,0,8'h16}, '{1,0,0,0,8'h16},
            '{1,0,0,0,8'h16}, '{1,0,1,0,8'h1E}, '{0,0,0,0,8'h16}, '{1,0,1,0,8'h16},
            '{1,0,0,0,8'h16}, '{1,0,1,0,8'h1E}, '{0,0,1,0,8'h16}, '{1,1,0,0,8'hD4}};
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", outs(), 8'h16);
    resetN = 1'b1;
    foreach (tbl[i]) begin
      step(tbl[i].fs, tbl[i].c0, tbl[i].c1, tbl[i].rs);
      check($sformatf("vec%0d", i), outs(), tbl[i].exp);
    end
    repeat (59) step(1, 0, 0, 0);
    check1("still_crashed_59", crash_active, 1'b1);
    step(1, 0, 0, 0);
    check1("respawn_after_60", invulnerable, 1'b1);
    repeat (7) step(1, 1, 0, 0);
    step(1, 0, 0, 0);
    check1("blink_off_at_8", player_visible, 1'b0);
    check1("respawn_hit_ignored", lives == 2'd2, 1'b1);
    repeat (81) step(1, 0, 0, 0);
    check1("still_invuln_89", invulnerable, 1'b1);
    step(1, 0, 0, 0);
    check("driving_after_90", outs(), 8'h14);
    step(1, 1, 0, 0);
    repeat (150) step(1, 0, 0, 0);
    check("lives1_driving", outs(), 8'h12);
    step(1, 1, 0, 0);
    check("game_over", outs(), 8'h51);
    repeat (3) step(1, 1, 1, 0);
    check("game_over_sticky", outs(), 8'h51);
    step(0, 0, 0, 1);
    check("restart", outs(), 8'h16);
    step(1, 0, 0, 0);
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 1, 0); pulses += int'(fuel_pickup);
      step(0, 0, 1, 0); pulses += int'(fuel_pickup);
    end
    check("fuel_pulses_held", 8'(pulses), 8'd1);
    step(1, 0, 0, 0);
    step(1, 0, 1, 0);
    check1("fuel_second_pulse", fuel_pickup, 1'b1);
    step(0, 0, 0, 0);
    check1("fuel_pulse_drops", fuel_pickup, 1'b0);
    step(1, 0, 0, 0);
    step(1, 1, 1, 0);
    check("hit_and_fuel", outs(), 8'hD4);
    repeat (29) step(1, 0, 0, 0);
    frame_start = 0; collisions = '0; restart = 0;
    #3 resetN = 1'b0;
    #1 check("async_reset", outs(), 8'h16);
    model_reset();
    @(posedge clk); #1;
    resetN = 1'b1;
    step(0, 0, 0, 0);
    check("after_reset_release", outs(), 8'h16);
    for (int i = 0; i < 4000; i++)
      step(1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)),
           $urandom_range(0, 299) == 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
